uart_mmio_ctrl: RTL and testbench
=================================

Name: uart_mmio_ctrl

Overview:
Memory-mapped 8N1 UART controller. It sits directly downstream of the processor's MEM stage, as the UART slice of the peripheral address space. It consumes the MEM-stage read/write strobes, address and store data, and returns read data combinationally in the same cycle. It also drives the UART pins and the level interrupt that feeds the core's interrupt input (uart_send).

Parameters:
OSR_DIV, 163, sysclk cycles per 16x oversample tick (25 MHz / (9600*16))
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)

Ports:
sysclk  in  1  single clock; all state and bus strobes are synchronous to it
reset  in  1  asynchronous, active-high
MemRd  in  1  read strobe, one sysclk cycle per access
MemWr  in  1  write strobe, one sysclk cycle per access
Address  in  32  byte address; only full matches on the map below are decoded
WriteData  in  32  store data
ReadData  out  32  combinational; 0 when not decoded or MemRd=0
UART_RX  in  1  asynchronous serial input, idle high
UART_TX  out  1  serial output, idle high
uart_irq  out  1  level interrupt to the core

Behaviour:
- Register map:
  - 0x40000018 TXD: write pushes WriteData[7:0] into the TX FIFO; reads return 0.
  - 0x4000001C RXD: read returns {24'd0, rx_data}; the read clears rx_valid at the clock edge.
  - 0x40000020 CON: bits [1:0] are RW, rest RO. [0] rx_ie, [1] tx_ie, [2] rx_valid, [3] tx_full, [4] tx_busy, [5] overrun, [6] frame_err.
  - A CON read clears bits [6:5] at the clock edge.
  - Writes to CON affect only bits [1:0].
- Reset values: UART_TX=1, uart_irq=0, ReadData=0 (strobes low). FIFO is empty. All CON bits are 0. Both FSMs are IDLE. The tick counter is 0.
- Tick generator:
  - Counter runs 0..OSR_DIV-1 and emits a one-cycle tick on wrap.
  - It runs free and is never reset by traffic.
- TX FIFO:
  - Write when not full: the entry is stored and count increments.
  - Write when full: the byte is dropped, no state changes.
  - Pointers wrap modulo TX_DEPTH.
  - tx_full = (count == TX_DEPTH).
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - Each state lasts 16 ticks. Data is sent LSB first.
  - STOP drives 1.
  - After STOP, a non-empty FIFO goes straight to START with no idle bit.
  - tx_busy = (state != IDLE).
  - A push and a pop in the same cycle leave count unchanged.
- RX synchronizer: UART_RX passes through 2 flops before any use.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge on the synced input resets the tick phase counter and goes to START.
  - START: at phase 8, if the line is high, it was a glitch; return to IDLE. Otherwise sample each data bit every 16 ticks at mid-bit.
  - STOP: sample at mid-bit.
    - If 0: set frame_err, discard the byte.
    - If 1 and rx_valid=0: load rx_data, set rx_valid.
    - If 1 and rx_valid=1: set overrun and keep the old data, unless an RXD read happens in the same cycle. In that case load the new byte, keep rx_valid=1, and do not set overrun.
  - Return to IDLE after STOP.
- Interrupt: uart_irq = (rx_ie & rx_valid) | (tx_ie & ~tx_busy & FIFO empty). It is registered, so it lags the condition by 1 cycle.
- Reset mid-frame: UART_TX returns to 1 immediately (asynchronous). A partial RX byte is lost.
- MemRd and MemWr both asserted: the write takes effect at the edge, and ReadData shows pre-edge state.

Decomposition:
- Shared package uart_pkg holds:
  - address constants UART_TXD_ADDR, UART_RXD_ADDR, UART_CON_ADDR;
  - CON bit index constants;
  - TX/RX state encodings;
  - the 16x oversample constant.
- Sub-module uart_rx_fsm holds the synchronizer, start validation, bit sampling and the stop check. It outputs a byte plus one-cycle done/frame_err pulses.
- The TX path and FIFO stay in the top level.

Test Plan:
- Reset with reset=1 mid-TX frame -> UART_TX=1 asynchronously; after release, CON reads 0x00 and ReadData=0.
- Write 0x55 to 0x40000018 with tx_ie=1 -> the start bit begins within 1 tick. Each bit lasts 16*OSR_DIV cycles, pattern 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop). CON[4]=1 during the frame. uart_irq rises once the FIFO is empty and TX is idle.
- Push 6 bytes 0x01..0x06 back-to-back with TX_DEPTH=4 -> 0x01 pops immediately. 0x02..0x05 fill the FIFO (tx_full=1), 0x06 is dropped. The line carries 0x01..0x05 with no idle gaps.
- Drive 0xA3 on UART_RX at 9600 baud with rx_ie=1 -> rx_valid=1 and uart_irq=1. An RXD read returns 0x000000A3, then rx_valid=0 and uart_irq drops.
- Send 0x11 then 0x22 without reading -> RXD=0x11 and CON[5]=1. Reading CON clears bit 5.
- 0.4-bit low glitch on UART_RX -> no byte is received and no flags are set. A frame with stop=0 -> frame_err=1 and rx_valid unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the memory-mapped UART.
package uart_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int unsigned CON_RX_IE     = 0;
  localparam int unsigned CON_TX_IE     = 1;
  localparam int unsigned CON_RX_VALID  = 2;
  localparam int unsigned CON_TX_FULL   = 3;
  localparam int unsigned CON_TX_BUSY   = 4;
  localparam int unsigned CON_OVERRUN   = 5;
  localparam int unsigned CON_FRAME_ERR = 6;

  // Oversample ticks per bit; phase counters are sized for it.
  localparam int unsigned OSR = 16;
  typedef logic [3:0] phase_t;
  localparam phase_t PHASE_LAST  = 4'(OSR - 1);
  localparam phase_t RX_MID_TICK = 4'(OSR / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 receiver: input synchronizer, start-bit validation, mid-bit sampling
// and stop-bit check. Emits one-cycle done / frame-error pulses.
module uart_rx_fsm
  import uart_pkg::*;
(
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_ferr
);

  logic      sync1, sync2, rx_prev;
  rx_state_e state, state_n;
  phase_t    phase, phase_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic       fall;

  assign fall    = rx_prev & ~sync2;
  assign rx_byte = shift;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_pin;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // State register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state   <= RX_IDLE;
      phase   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  // Next-state logic; phase counts ticks within the current bit.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    rx_done   = 1'b0;
    rx_ferr   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          phase_n = '0;
          state_n = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (phase == RX_MID_TICK) begin
            // Mid start bit: high means the edge was a glitch.
            if (sync2) begin
              state_n = RX_IDLE;
            end else begin
              phase_n   = '0;
              bit_idx_n = '0;
              state_n   = RX_DATA;
            end
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (phase == PHASE_LAST) begin
            phase_n = '0;
            shift_n = {sync2, shift[7:1]};
            if (bit_idx == 3'd7) state_n = RX_STOP;
            else                 bit_idx_n = bit_idx + 3'd1;
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (phase == PHASE_LAST) begin
            rx_done = sync2;
            rx_ferr = ~sync2;
            phase_n = '0;
            state_n = RX_IDLE;
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped 8N1 UART: register decode, TX FIFO and transmitter,
// status/control register and level interrupt.
module uart_mmio_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OSR_DIV  = 163,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        uart_irq
);

  localparam int unsigned DIV_W = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam int unsigned PTR_W = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // ---------------- oversample tick ----------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(OSR_DIV - 1));

  // Free-running divider, independent of bus or line traffic.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---------------- bus decode ----------------
  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic unused_wdata;

  assign sel_txd = (Address == UART_TXD_ADDR);
  assign sel_rxd = (Address == UART_RXD_ADDR);
  assign sel_con = (Address == UART_CON_ADDR);
  assign wr_txd  = MemWr & sel_txd;
  assign wr_con  = MemWr & sel_con;
  assign rd_rxd  = MemRd & sel_rxd;
  assign rd_con  = MemRd & sel_con;
  assign unused_wdata = ^WriteData[31:8];

  // ---------------- TX FIFO ----------------
  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (fifo_cnt == CNT_W'(TX_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = wr_txd & ~fifo_full;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge sysclk) begin
    if (push) fifo_mem[wr_ptr] <= WriteData[7:0];
  end

  // Pointers wrap naturally since TX_DEPTH is a power of two.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  tx_state_e  tx_state, tx_state_n;
  phase_t     tx_phase, tx_phase_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       tx_line, tx_line_n, tx_load, tx_busy;

  assign tx_busy = (tx_state != TX_IDLE);
  assign UART_TX = tx_line;

  // TX state register; the line flop resets high so the pin idles at once.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_phase <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_phase <= tx_phase_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // TX next-state; line level is decoded from the next state so it is registered.
  always_comb begin
    tx_state_n = tx_state;
    tx_phase_n = tx_phase;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_load    = 1'b0;
    case (tx_state)
      TX_IDLE: tx_load = ~fifo_empty;
      TX_START: begin
        if (tick) begin
          if (tx_phase == PHASE_LAST) begin
            tx_phase_n = '0;
            tx_bit_n   = '0;
            tx_state_n = TX_DATA;
          end else begin
            tx_phase_n = tx_phase + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_phase == PHASE_LAST) begin
            tx_phase_n = '0;
            tx_shift_n = {1'b1, tx_shift[7:1]};
            if (tx_bit == 3'd7) tx_state_n = TX_STOP;
            else                tx_bit_n   = tx_bit + 3'd1;
          end else begin
            tx_phase_n = tx_phase + 4'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_phase == PHASE_LAST) begin
            tx_phase_n = '0;
            if (!fifo_empty) tx_load    = 1'b1;
            else             tx_state_n = TX_IDLE;
          end else begin
            tx_phase_n = tx_phase + 4'd1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // Loading from IDLE or straight out of STOP shares one path.
    if (tx_load) begin
      tx_shift_n = fifo_mem[rd_ptr];
      tx_phase_n = '0;
      tx_state_n = TX_START;
    end
    pop = tx_load;
    case (tx_state_n)
      TX_START: tx_line_n = 1'b0;
      TX_DATA:  tx_line_n = tx_shift_n[0];
      default:  tx_line_n = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;

  uart_rx_fsm u_rx (
    .sysclk  (sysclk),
    .reset   (reset),
    .tick    (tick),
    .rx_pin  (UART_RX),
    .rx_byte (rx_byte),
    .rx_done (rx_done),
    .rx_ferr (rx_ferr)
  );

  // ---------------- control / status ----------------
  logic       rx_ie, tx_ie, rx_valid, overrun, frame_err;
  logic [7:0] rx_data;

  // Control bits, receive holding register and sticky error flags.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_ie     <= 1'b0;
      tx_ie     <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      if (wr_con) begin
        rx_ie <= WriteData[CON_RX_IE];
        tx_ie <= WriteData[CON_TX_IE];
      end
      if (rd_con) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rd_rxd) rx_valid <= 1'b0;
      if (rx_ferr) frame_err <= 1'b1;
      // A byte arriving while the old one is read in the same cycle replaces it.
      if (rx_done) begin
        if (!rx_valid || rd_rxd) begin
          rx_data  <= rx_byte;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) uart_irq <= 1'b0;
    else       uart_irq <= (rx_ie & rx_valid) | (tx_ie & ~tx_busy & fifo_empty);
  end

  // Combinational read mux; shows pre-edge state.
  logic [31:0] con_word;
  always_comb begin
    con_word                = '0;
    con_word[CON_RX_IE]     = rx_ie;
    con_word[CON_TX_IE]     = tx_ie;
    con_word[CON_RX_VALID]  = rx_valid;
    con_word[CON_TX_FULL]   = fifo_full;
    con_word[CON_TX_BUSY]   = tx_busy;
    con_word[CON_OVERRUN]   = overrun;
    con_word[CON_FRAME_ERR] = frame_err;
    ReadData = '0;
    if (MemRd) begin
      if (sel_rxd)      ReadData = {24'd0, rx_data};
      else if (sel_con) ReadData = con_word;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl with a shortened baud divider.
module tb_uart_mmio_ctrl;
  import uart_pkg::*;

  localparam int unsigned OSR_DIV  = 4;
  localparam int unsigned TX_DEPTH = 4;
  localparam int unsigned BIT      = 16 * OSR_DIV;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        MemRd  = 1'b0;
  logic        MemWr  = 1'b0;
  logic [31:0] Address   = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        UART_RX = 1'b1;
  logic        UART_TX;
  logic        uart_irq;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  int unsigned start_q[$];

  uart_mmio_ctrl #(.OSR_DIV(OSR_DIV), .TX_DEPTH(TX_DEPTH)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .UART_RX   (UART_RX),
    .UART_TX   (UART_TX),
    .uart_irq  (uart_irq)
  );

  always #5 sysclk = ~sysclk;
  always @(negedge sysclk) cyc <= cyc + 1;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge sysclk);
    MemWr = 1'b1; MemRd = 1'b0; Address = a; WriteData = d;
    @(posedge sysclk); #1;
    MemWr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge sysclk);
    MemRd = 1'b1; MemWr = 1'b0; Address = a;
    #1 d = ReadData;
    @(posedge sysclk); #1;
    MemRd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge sysclk);
    UART_RX = 1'b0;
    repeat (BIT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BIT) @(negedge sysclk);
    end
    UART_RX = stop;
    repeat (BIT) @(negedge sysclk);
    UART_RX = 1'b1;
  endtask

  // TX line monitor: decodes frames mid-bit and pops the expected byte.
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge UART_TX);
      if (mon_en && !reset) begin
        start_q.push_back(cyc);
        repeat (BIT / 2) @(negedge sysclk);
        checks++;
        if (UART_TX !== 1'b0) begin
          errors++; $display("FAIL tx_start_bit got %b want 0", UART_TX);
        end
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge sysclk);
          got[i] = UART_TX;
        end
        repeat (BIT) @(negedge sysclk);
        checks++;
        if (UART_TX !== 1'b1) begin
          errors++; $display("FAIL tx_stop_bit got %b want 1", UART_TX);
        end
        checks++;
        if (tx_q.size() == 0) begin
          errors++; $display("FAIL tx_unexpected_byte got %h want none", got);
        end else if (got !== tx_q[0]) begin
          errors++; $display("FAIL tx_byte got %h want %h", got, tx_q[0]);
          void'(tx_q.pop_front());
        end else begin
          void'(tx_q.pop_front());
        end
      end
    end
  end

  task automatic wait_tx_drain(input int unsigned budget);
    int unsigned n = 0;
    while (tx_q.size() != 0 && n < budget) begin
      @(negedge sysclk); n++;
    end
    checks++;
    if (tx_q.size() != 0) begin
      errors++; $display("FAIL tx_drain_timeout pending %0d want 0", tx_q.size());
    end
  endtask

  task automatic check_rxd();
    logic [31:0] d;
    bus_read(UART_RXD_ADDR, d);
    checks++;
    if (rx_q.size() == 0) begin
      errors++; $display("FAIL rxd_unexpected got %h want none", d);
    end else begin
      if (d !== {24'd0, rx_q[0]}) begin
        errors++; $display("FAIL rxd_data got %h want %h", d, {24'd0, rx_q[0]});
      end
      void'(rx_q.pop_front());
    end
  endtask

  task automatic check_con(input string name, input logic [31:0] want);
    logic [31:0] d;
    bus_read(UART_CON_ADDR, d);
    checks++;
    if (d !== want) begin
      errors++; $display("FAIL %s got %h want %h", name, d, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    checks++;
    if (UART_TX !== 1'b1 || uart_irq !== 1'b0 || ReadData !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got tx=%b irq=%b rd=%h want 1 0 0", UART_TX, uart_irq, ReadData);
    end
    @(negedge sysclk); reset = 1'b0;
    bus_write(UART_TXD_ADDR, 32'hF0);
    repeat (BIT * 2 + BIT / 2) @(negedge sysclk);
    checks++;
    if (UART_TX !== 1'b0) begin
      errors++; $display("FAIL reset_midframe_line got %b want 0", UART_TX);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (UART_TX !== 1'b1) begin
      errors++; $display("FAIL reset_async_tx got %b want 1", UART_TX);
    end
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    check_con("reset_con", 32'h00);
    checks++;
    if (ReadData !== 32'h0 || uart_irq !== 1'b0) begin
      errors++; $display("FAIL reset_idle got rd=%h irq=%b want 0 0", ReadData, uart_irq);
    end
  endtask

  task automatic test_tx_single();
    int unsigned n = 0;
    bus_write(UART_CON_ADDR, 32'h2);
    tx_q.push_back(8'h55);
    bus_write(UART_TXD_ADDR, 32'h55);
    while (UART_TX !== 1'b0 && n < 4 * BIT) begin
      @(posedge sysclk); #1; n++;
    end
    checks++;
    if (n > OSR_DIV) begin
      errors++; $display("FAIL tx_start_latency got %0d want <= %0d", n, OSR_DIV);
    end
    repeat (3 * BIT) @(negedge sysclk);
    check_con("tx_busy_con", 32'h12);
    checks++;
    if (uart_irq !== 1'b0) begin
      errors++; $display("FAIL tx_irq_busy got %b want 0", uart_irq);
    end
    wait_tx_drain(20 * BIT);
    repeat (BIT) @(negedge sysclk);
    checks++;
    if (uart_irq !== 1'b1) begin
      errors++; $display("FAIL tx_irq_idle got %b want 1", uart_irq);
    end
    check_con("tx_idle_con", 32'h02);
  endtask

  task automatic test_back_to_back();
    int unsigned d;
    start_q.delete();
    // One byte leaves for the shifter at once; TX_DEPTH more fit; the rest drop.
    for (int unsigned i = 1; i <= 6; i++) begin
      if (i <= TX_DEPTH + 1) tx_q.push_back(8'(i));
      bus_write(UART_TXD_ADDR, i);
    end
    check_con("b2b_full_con", 32'h1A);
    wait_tx_drain(60 * BIT);
    checks++;
    if (start_q.size() != TX_DEPTH + 1) begin
      errors++; $display("FAIL b2b_frames got %0d want %0d", start_q.size(), TX_DEPTH + 1);
    end else begin
      for (int k = 1; k < start_q.size(); k++) begin
        d = start_q[k] - start_q[k-1];
        checks++;
        if ((k == 1 && (d > 10 * BIT || d < 10 * BIT - OSR_DIV + 1)) ||
            (k != 1 && d != 10 * BIT)) begin
          errors++; $display("FAIL b2b_spacing frame %0d got %0d want %0d", k, d, 10 * BIT);
        end
      end
    end
    repeat (BIT) @(negedge sysclk);
    check_con("b2b_idle_con", 32'h02);
  endtask

  task automatic test_rx_basic();
    int unsigned n = 0;
    bus_write(UART_CON_ADDR, 32'h1);
    rx_q.push_back(8'hA3);
    send_rx(8'hA3, 1'b1);
    while (uart_irq !== 1'b1 && n < BIT) begin
      @(negedge sysclk); n++;
    end
    checks++;
    if (uart_irq !== 1'b1) begin
      errors++; $display("FAIL rx_irq_set got %b want 1", uart_irq);
    end
    check_con("rx_valid_con", 32'h05);
    check_rxd();
    repeat (2) @(negedge sysclk);
    checks++;
    if (uart_irq !== 1'b0) begin
      errors++; $display("FAIL rx_irq_clear got %b want 0", uart_irq);
    end
    check_con("rx_cleared_con", 32'h01);
  endtask

  task automatic test_overrun();
    rx_q.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) @(negedge sysclk);
    check_con("ovr_set_con", 32'h25);
    check_con("ovr_clear_con", 32'h05);
    check_rxd();
    check_con("ovr_done_con", 32'h01);
  endtask

  task automatic test_glitch_frame_err();
    @(negedge sysclk);
    UART_RX = 1'b0;
    repeat (BIT * 2 / 5) @(negedge sysclk);
    UART_RX = 1'b1;
    repeat (2 * BIT) @(negedge sysclk);
    check_con("glitch_con", 32'h01);
    checks++;
    if (uart_irq !== 1'b0) begin
      errors++; $display("FAIL glitch_irq got %b want 0", uart_irq);
    end
    rx_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    send_rx(8'h3C, 1'b0);
    repeat (BIT) @(negedge sysclk);
    check_con("ferr_set_con", 32'h45);
    check_con("ferr_clear_con", 32'h05);
    check_rxd();
  endtask

  task automatic test_rdwr_decode();
    logic [31:0] d;
    @(negedge sysclk);
    MemRd = 1'b1; MemWr = 1'b1; Address = UART_CON_ADDR; WriteData = 32'h3;
    #1 d = ReadData;
    @(posedge sysclk); #1;
    MemRd = 1'b0; MemWr = 1'b0;
    checks++;
    if (d !== 32'h01) begin
      errors++; $display("FAIL rdwr_pre_edge got %h want 00000001", d);
    end
    check_con("rdwr_post_con", 32'h03);
    bus_read(UART_TXD_ADDR, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL txd_read got %h want 0", d);
    end
    bus_read(32'h4000_0024, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL undecoded_read got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_tx_single();
    test_back_to_back();
    test_rx_basic();
    test_overrun();
    test_glitch_frame_err();
    test_rdwr_decode();
    checks++;
    if (tx_q.size() != 0 || rx_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got tx=%0d rx=%0d want 0 0", tx_q.size(), rx_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(60000 * 10);
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
